// File: rtl/adder_arbiter.sv
// Round-robin front end that shares one 8-bit adder between NUM_REQ requesters.
// A request is granted in IDLE. The operands are captured at the grant. The adder
// result is registered in CALC. DONE raises a one-cycle done pulse to the winner.
// Only one addition is in flight at a time.
module adder_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   op_a,
  input  logic [8*NUM_REQ-1:0]   op_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             sum,
  output logic                   ov,
  output logic                   busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0] sel_idx;
  logic            sel_found;
  logic            latch_ops;
  logic [7:0]      opa_q, opb_q;
  logic [7:0]      sum_q;
  logic            ov_q;
  logic [8:0]      add_res;

  // Ripple-carry 8-bit adder. Returns {carry_out, sum}.
  function automatic logic [8:0] add8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    logic       c;
    c = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {c, s};
  endfunction

  // Round-robin pick. The scan starts at ptr+1 and wraps modulo NUM_REQ.
  // The loop walks from the farthest candidate to the nearest one, so the
  // nearest set request is the last to overwrite the result and wins.
  function automatic logic [IdxW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IdxW-1:0]    ptr);
    logic [IdxW:0] res;
    int unsigned   cand;
    res = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (r[IdxW'(cand)]) begin
        res = {1'b1, IdxW'(cand)};
      end
    end
    return res;
  endfunction

  // Pick the next requester after the last winner.
  always_comb begin
    {sel_found, sel_idx} = rr_pick(req, rr_ptr_q);
  end

  // Next-state logic. A grant is only taken from IDLE.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    latch_ops = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d   = StCalc;
          rr_ptr_d  = sel_idx;
          gnt_idx_d = sel_idx;
          latch_ops = 1'b1;
        end
      end
      StCalc:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, round-robin pointer and winner index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rr_ptr_q  <= IdxW'(NUM_REQ - 1);
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  // Capture the winner's operands at grant time.
  // Later changes on the operand bus cannot affect the addition in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (latch_ops) begin
      opa_q <= op_a[8*sel_idx +: 8];
      opb_q <= op_b[8*sel_idx +: 8];
    end
  end

  // The adder only ever sees the captured operands.
  always_comb begin
    add_res = add8(opa_q, opb_q);
  end

  // Register the result at the end of CALC. It holds until the next CALC completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      ov_q  <= 1'b0;
    end else if (state_q == StCalc) begin
      sum_q <= add_res[7:0];
      ov_q  <= add_res[8];
    end
  end

  // Decode the one-hot grant and done outputs from the state and the winner index.
  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q != StIdle) begin
      gnt[gnt_idx_q] = 1'b1;
    end
    if (state_q == StDone) begin
      done[gnt_idx_q] = 1'b1;
    end
  end

  assign busy = (state_q != StIdle);
  assign sum  = sum_q;
  assign ov   = ov_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter.
// Single-requester vectors are table driven.
// Arbitration order, latched operands and reset abort are covered by hand sequences.
module tb_adder_arbiter;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] op_a;
  logic [8*N-1:0] op_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [7:0]     sum;
  logic           ov;
  logic           busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[6];

  adder_arbiter #(.NUM_REQ(N)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .op_a (op_a),
    .op_b (op_b),
    .gnt  (gnt),
    .done (done),
    .sum  (sum),
    .ov   (ov),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle. Sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " gnt"},  32'(gnt),  32'h0);
    chk({name, " done"}, 32'(done), 32'h0);
    chk({name, " busy"}, 32'(busy), 32'h0);
  endtask

  // Run one isolated addition. The operand bus is scrambled after the grant.
  task automatic run_one(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_s, input logic exp_o);
    req = '0;
    req[idx] = 1'b1;
    op_a[8*idx +: 8] = a;
    op_b[8*idx +: 8] = b;
    tick();
    chk("vec calc gnt",  32'(gnt),  32'(1 << idx));
    chk("vec calc done", 32'(done), 32'h0);
    chk("vec calc busy", 32'(busy), 32'h1);
    req = '0;
    op_a[8*idx +: 8] = ~a;
    op_b[8*idx +: 8] = ~b;
    tick();
    chk("vec done gnt",  32'(gnt),  32'(1 << idx));
    chk("vec done done", 32'(done), 32'(1 << idx));
    chk("vec sum",       32'(sum),  32'(exp_s));
    chk("vec ov",        32'(ov),   32'(exp_o));
    tick();
    chk_idle("vec after");
    chk("vec sum held", 32'(sum), 32'(exp_s));
  endtask

  // One grant with req held: CALC, then DONE, then IDLE.
  task automatic rr_grant(input int idx, input logic [7:0] exp_s);
    tick();
    chk("rr gnt", 32'(gnt), 32'(1 << idx));
    tick();
    chk("rr done", 32'(done), 32'(1 << idx));
    chk("rr sum",  32'(sum),  32'(exp_s));
    tick();
    chk("rr idle busy", 32'(busy), 32'h0);
  endtask

  initial begin
    vecs[0] = '{idx: 0, a: 8'h12, b: 8'h34, exp_sum: 8'h46, exp_ov: 1'b0};
    vecs[1] = '{idx: 2, a: 8'hFF, b: 8'h01, exp_sum: 8'h00, exp_ov: 1'b1};
    vecs[2] = '{idx: 2, a: 8'h80, b: 8'h80, exp_sum: 8'h00, exp_ov: 1'b1};
    vecs[3] = '{idx: 2, a: 8'h7F, b: 8'h80, exp_sum: 8'hFF, exp_ov: 1'b0};
    vecs[4] = '{idx: 1, a: 8'hC8, b: 8'h64, exp_sum: 8'h2C, exp_ov: 1'b1};
    vecs[5] = '{idx: 3, a: 8'h5A, b: 8'hA5, exp_sum: 8'hFF, exp_ov: 1'b0};

    reset = 1'b1;
    req   = '0;
    op_a  = '0;
    op_b  = '0;

    // Hold reset for 3 cycles: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("reset");
      chk("reset sum", 32'(sum), 32'h0);
      chk("reset ov",  32'(ov),  32'h0);
    end
    reset = 1'b0;
    tick();
    chk_idle("idle no req");

    // Table-driven single additions.
    for (int i = 0; i < 6; i++) begin
      run_one(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_ov);
    end

    // An operand change during CALC must not reach the adder.
    req = 4'b0001;
    op_a[7:0] = 8'h01;
    op_b[7:0] = 8'h01;
    tick();
    req = '0;
    op_a[7:0] = 8'hAA;
    tick();
    chk("latch done", 32'(done), 32'h1);
    chk("latch sum",  32'(sum),  32'h02);
    chk("latch ov",   32'(ov),   32'h0);
    tick();

    // Round robin with all four requests held after reset: order 0,1,2,3,0.
    op_a = {8'h40, 8'h30, 8'h20, 8'h10};
    op_b = {8'h04, 8'h03, 8'h02, 8'h01};
    reset = 1'b1;
    req = 4'b1111;
    tick();
    reset = 1'b0;
    rr_grant(0, 8'h11);
    rr_grant(1, 8'h22);
    rr_grant(2, 8'h33);
    rr_grant(3, 8'h44);
    rr_grant(0, 8'h11);
    // Only requesters 1 and 3 remain, so they alternate.
    req = 4'b1010;
    rr_grant(1, 8'h22);
    rr_grant(3, 8'h44);
    rr_grant(1, 8'h22);
    rr_grant(3, 8'h44);

    // Reset during CALC aborts the op and returns the pointer to NUM_REQ-1.
    // Without the reset, requester 2 would win next.
    req = 4'b0010;
    tick();
    chk("abort calc gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    tick();
    chk_idle("abort");
    chk("abort sum", 32'(sum), 32'h0);
    chk("abort ov",  32'(ov),  32'h0);
    reset = 1'b0;
    req = 4'b1111;
    tick();
    chk("post abort gnt", 32'(gnt), 32'h1);
    tick();
    chk("post abort done", 32'(done), 32'h1);
    chk("post abort sum",  32'(sum),  32'h11);
    req = '0;
    tick();
    chk_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
